// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: opcode field, opcodes, fetch defaults and state type.
package simplerisc_pkg;

  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned OPCODE_MSB      = 31;
  localparam int unsigned OPCODE_LSB      = 27;
  localparam int unsigned PC_STEP_DEFAULT = 4;

  localparam logic [4:0] OP_HLT = 5'b11111;
  localparam logic [4:0] OP_NOP = 5'b01101;
  localparam logic [4:0] OP_BEQ = 5'b10000;
  localparam logic [4:0] OP_BGT = 5'b10001;
  localparam logic [4:0] OP_B   = 5'b10010;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // True when the instruction's opcode field encodes hlt.
  function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, registers the fetched instruction for decode,
// follows branch redirects and stops permanently once a hlt has been captured.
module fetch_unit
  import simplerisc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       PC_STEP  = PC_STEP_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               if_ready,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  localparam int unsigned CNT_W = 32;

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                if_valid_q, if_valid_d;
  logic [INSTR_W-1:0]  if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic [CNT_W-1:0]    fetch_count_q, fetch_count_d;

  logic accept;
  logic running;
  logic capture;

  assign accept  = if_valid_q & if_ready;
  assign running = (state_q == RUN);
  // A redirect takes priority over capture, so a hlt at the flushed pc never halts.
  assign capture = running & (~if_valid_q | accept) & ~branch_taken;

  // Next-state: redirect, capture, drain, and saturating accept counter.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    fetch_count_d = fetch_count_q;

    if (accept && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + CNT_W'(1);
    end

    if (running && branch_taken) begin
      pc_d       = branch_target;
      if_valid_d = 1'b0;
    end else if (capture) begin
      if_instr_d = imem_instr;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + ADDR_W'(PC_STEP);
      if (is_hlt(imem_instr)) begin
        state_d = HALT;
      end
    end else if (accept) begin
      if_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = fetch_count_q;

endmodule
